// File: rtl/alarm_ctrl.sv
// Alarm controller: matches the running time against the alarm time and drives
// the buzzer through a ring / snooze / timeout state machine. Optional beep pattern: ALARM_BEEP_EN.
module alarm_ctrl #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int SNOOZE_MAX  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    input  logic [5:0] alarm_min,
    input  logic [4:0] alarm_hour,
    input  logic       alarm_en,
    input  logic       stop,
    input  logic       snooze,
    output logic       ring,
    output logic       snoozing,
    output logic [1:0] state,
    output logic [1:0] snooze_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SECS - 1);
    localparam logic [1:0] CNT_MAX     = 2'(SNOOZE_MAX);

    state_t     state_r;
    state_t     state_s;
    logic [8:0] timer_r;
    logic [8:0] timer_s;
    logic [1:0] cnt_r;
    logic [1:0] cnt_s;
    logic       match_d_r;
    logic       match_s;
    logic       trigger_s;
    logic       ring_r;
    logic       ring_s;
    logic       snoozing_r;

    assign match_s   = alarm_en & (min == alarm_min) & (hour == alarm_hour);
    // Rising edge only, so a stopped alarm stays quiet for the rest of the minute.
    assign trigger_s = match_s & ~match_d_r;

    // Next-state, timer and snooze-count logic; stop/disable outrank snooze, which outranks the tick.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_s = ST_RINGING;
                    cnt_s   = 2'd0;
                    timer_s = 9'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RINGING: begin
                if (!alarm_en || stop) begin
                    state_s = ST_IDLE;
                    timer_s = 9'd0;
                end else if (snooze && (cnt_r < CNT_MAX)) begin
                    state_s = ST_SNOOZE;
                    cnt_s   = cnt_r + 2'd1;
                    timer_s = 9'd0;
                end else if (sec_tick) begin
                    if (timer_r == RING_LAST) begin
                        state_s = ST_IDLE;
                        timer_s = 9'd0;
                    end else begin
                        timer_s = timer_r + 9'd1;
                    end
                end else begin
                    state_s = ST_RINGING;
                end
            end
            ST_SNOOZE: begin
                if (!alarm_en || stop) begin
                    state_s = ST_IDLE;
                    timer_s = 9'd0;
                end else if (sec_tick) begin
                    if (timer_r == SNOOZE_LAST) begin
                        state_s = ST_RINGING;
                        timer_s = 9'd0;
                    end else begin
                        timer_s = timer_r + 9'd1;
                    end
                end else begin
                    state_s = ST_SNOOZE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = 9'd0;
            end
        endcase
    end

`ifdef ALARM_BEEP_EN
    logic phase_r;
    logic phase_s;

    // Beep phase: starts high on each RINGING entry, flips every second while ringing.
    always_comb begin
        phase_s = phase_r;
        if ((state_s == ST_RINGING) && (state_r != ST_RINGING)) begin
            phase_s = 1'b1;
        end else if ((state_s == ST_RINGING) && sec_tick) begin
            phase_s = ~phase_r;
        end else begin
            phase_s = phase_r;
        end
        ring_s = (state_s == ST_RINGING) & phase_s;
    end

    // Beep phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= 1'b0;
        end else begin
            phase_r <= phase_s;
        end
    end
`else
    assign ring_s = (state_s == ST_RINGING);
`endif

    // State, timer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            timer_r    <= 9'd0;
            cnt_r      <= 2'd0;
            match_d_r  <= 1'b0;
            ring_r     <= 1'b0;
            snoozing_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            cnt_r      <= cnt_s;
            match_d_r  <= match_s;
            ring_r     <= ring_s;
            snoozing_r <= (state_s == ST_SNOOZE);
        end
    end

    assign state      = state_r;
    assign snooze_cnt = cnt_r;
    assign ring       = ring_r;
    assign snoozing   = snoozing_r;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_alarm_ctrl;

`ifdef ALARM_BEEP_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick;
    logic [5:0] min;
    logic [4:0] hour;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hour;
    logic       alarm_en;
    logic       stop;
    logic       snooze;
    logic       ring;
    logic       snoozing;
    logic [1:0] state;
    logic [1:0] snooze_cnt;

    typedef struct {
        logic [1:0] st;
        logic       rg;
        logic       sz;
        logic [1:0] cnt;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    alarm_ctrl dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick),
        .min(min), .hour(hour), .alarm_min(alarm_min), .alarm_hour(alarm_hour),
        .alarm_en(alarm_en), .stop(stop), .snooze(snooze),
        .ring(ring), .snoozing(snoozing), .state(state), .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [1:0] st, input logic rg, input logic [1:0] cnt,
                              input string name);
        exp_t e;
        e.st   = st;
        e.rg   = rg;
        e.sz   = (st == 2'd2);
        e.cnt  = cnt;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sec_tick = 1'b1;
            cyc();
            sec_tick = 1'b0;
            cyc();
        end
    endtask

    task automatic retrigger();
        min = 6'd31;
        cyc();
        min = 6'd30;
        cyc();
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
    endtask

    // Monitor: compare every pending expectation against the settled outputs.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (state === e.st && ring === e.rg && snoozing === e.sz && snooze_cnt === e.cnt) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got state=%0d ring=%0b snoozing=%0b cnt=%0d, want state=%0d ring=%0b snoozing=%0b cnt=%0d",
                         e.name, state, ring, snoozing, snooze_cnt, e.st, e.rg, e.sz, e.cnt);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sec_tick = 1'b0; stop = 1'b0; snooze = 1'b0;
        alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
        hour = 5'd7; min = 6'd29;
        cyc();
        n_checks++;
        if (state === 2'd0 && ring === 1'b0 && snoozing === 1'b0 && snooze_cnt === 2'd0) begin
            n_pass++;
        end else begin
            $display("FAIL reset_direct: got state=%0d ring=%0b snoozing=%0b cnt=%0d, want all 0",
                     state, ring, snoozing, snooze_cnt);
        end
        expect_out(2'd0, 1'b0, 2'd0, "reset");
        rst = 1'b0;
        cyc();
        expect_out(2'd0, 1'b0, 2'd0, "idle_0729");

        min = 6'd30;
        cyc();
        expect_out(2'd1, 1'b1, 2'd0, "trigger_0730");
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_out(2'd0, 1'b0, 2'd0, "stop");
        repeat (3) cyc();
        expect_out(2'd0, 1'b0, 2'd0, "hold_no_rering");
        min = 6'd31;
        cyc();
        expect_out(2'd0, 1'b0, 2'd0, "idle_0731");
        min = 6'd30;
        cyc();
        expect_out(2'd1, 1'b1, 2'd0, "rering_0730");

        ticks(59);
        expect_out(2'd1, BEEP ? 1'b0 : 1'b1, 2'd0, "ring_59_ticks");
        ticks(1);
        expect_out(2'd0, 1'b0, 2'd0, "timeout_60th_tick");

        retrigger();
        expect_out(2'd1, 1'b1, 2'd0, "beep_0");
        ticks(1);
        expect_out(2'd1, BEEP ? 1'b0 : 1'b1, 2'd0, "beep_1");
        ticks(1);
        expect_out(2'd1, 1'b1, 2'd0, "beep_2");
        ticks(1);
        expect_out(2'd1, BEEP ? 1'b0 : 1'b1, 2'd0, "beep_3");

        pulse_snooze();
        expect_out(2'd2, 1'b0, 2'd1, "snooze1");
        ticks(299);
        expect_out(2'd2, 1'b0, 2'd1, "snooze1_299");
        ticks(1);
        expect_out(2'd1, 1'b1, 2'd1, "wake1_300th_tick");

        stop = 1'b1; snooze = 1'b1;
        cyc();
        stop = 1'b0; snooze = 1'b0;
        expect_out(2'd0, 1'b0, 2'd1, "stop_beats_snooze");

        retrigger();
        expect_out(2'd1, 1'b1, 2'd0, "retrig_cnt_clear");
        pulse_snooze();
        ticks(300);
        expect_out(2'd1, 1'b1, 2'd1, "wake_cnt1");
        snooze = 1'b1; sec_tick = 1'b1;
        cyc();
        snooze = 1'b0; sec_tick = 1'b0;
        expect_out(2'd2, 1'b0, 2'd2, "snooze_plus_tick");
        cyc();
        ticks(299);
        expect_out(2'd2, 1'b0, 2'd2, "snooze2_timer_zeroed");
        ticks(1);
        expect_out(2'd1, 1'b1, 2'd2, "wake_cnt2");
        pulse_snooze();
        expect_out(2'd2, 1'b0, 2'd3, "snooze3");
        ticks(300);
        expect_out(2'd1, 1'b1, 2'd3, "wake_cnt3");
        pulse_snooze();
        expect_out(2'd1, 1'b1, 2'd3, "snooze4_ignored");

        stop = 1'b1;
        cyc();
        stop = 1'b0;
        expect_out(2'd0, 1'b0, 2'd3, "stop_cnt_held");
        retrigger();
        pulse_snooze();
        expect_out(2'd2, 1'b0, 2'd1, "snooze_before_disable");
        alarm_en = 1'b0;
        cyc();
        expect_out(2'd0, 1'b0, 2'd1, "disable_in_snooze");
        alarm_en = 1'b1;
        cyc();
        expect_out(2'd1, 1'b1, 2'd0, "enable_in_minute");

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        expect_out(2'd0, 1'b0, 2'd0, "rst_mid_ring");
        cyc();
        expect_out(2'd1, 1'b1, 2'd0, "rering_after_rst");

        repeat (2) @(negedge clk);
        if (n_pass != n_checks || q.size() != 0) begin
            $display("FAIL summary: %0d of %0d checks passed, %0d expectations unconsumed",
                     n_pass, n_checks, q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
